// File: rtl/list_walker.sv
// list_walker: walks a heap list of {value, next} node pairs and streams each value out
// Ports: clk_i/rst_ni clock and synchronous active-low reset; start_valid_i/start_head_i/start_ready_o
//        accept a head pointer; mem_req_o/mem_addr_o/mem_ready_i/mem_data_i single-outstanding read port;
//        out_valid_o/out_value_o/out_ready_i value stream; done_o/node_count_o/err_o walk result.
module list_walker #(
  parameter logic [15:0] NilValue = 16'h0000,
  parameter int          MaxNodes = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_valid_i,
  input  logic [15:0] start_head_i,
  output logic        start_ready_o,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [15:0] mem_data_i,
  output logic        out_valid_o,
  output logic [15:0] out_value_o,
  input  logic        out_ready_i,
  output logic        done_o,
  output logic [7:0]  node_count_o,
  output logic        err_o
);
  typedef enum logic [2:0] {IDLE, REQ_VAL, WAIT_VAL, REQ_NEXT, WAIT_NEXT, EMIT, DONE} state_t;
  state_t      state_q;
  logic        rdy_q, req_q, ov_q, done_q, err_q;
  logic [15:0] addr_q, value_q, next_q;
  logic [7:0]  cnt_q, cnt_d;
  assign cnt_d         = cnt_q + 8'd1;
  assign start_ready_o = rdy_q;
  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign out_valid_o   = ov_q;
  assign out_value_o   = value_q;
  assign done_o        = done_q;
  assign node_count_o  = cnt_q;
  assign err_o         = err_q;
  // addr_q doubles as the node pointer; it is only meaningful to memory while req_q is high
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      req_q   <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      value_q <= '0;
      next_q  <= '0;
      cnt_q   <= '0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (start_valid_i && rdy_q) begin
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= start_head_i;
            done_q  <= start_head_i == NilValue;
            req_q   <= start_head_i != NilValue;
            state_q <= start_head_i == NilValue ? DONE : REQ_VAL;
          end
        end
        REQ_VAL: state_q <= WAIT_VAL;
        WAIT_VAL: if (mem_ready_i) begin
          value_q <= mem_data_i;
          addr_q  <= addr_q + 16'd1;
          req_q   <= 1'b1;
          state_q <= REQ_NEXT;
        end
        REQ_NEXT: state_q <= WAIT_NEXT;
        WAIT_NEXT: if (mem_ready_i) begin
          next_q  <= mem_data_i;
          ov_q    <= 1'b1;
          state_q <= EMIT;
        end
        EMIT: if (out_ready_i) begin
          ov_q  <= 1'b0;
          cnt_q <= cnt_d;
          if (next_q == NilValue || cnt_d == 8'(MaxNodes)) begin
            err_q   <= next_q != NilValue;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            addr_q  <= next_q;
            req_q   <= 1'b1;
            state_q <= REQ_VAL;
          end
        end
        DONE: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
